// File: rtl/wavegen_pkg.sv
// Shared types, constants and elaboration-time helpers for the multi-channel wave generator.
package wavegen_pkg;

    localparam int unsigned MODE_WIDTH = 2;
    localparam int unsigned AMP_WIDTH  = 8;

    localparam logic [MODE_WIDTH-1:0] MODE_SINE   = 2'd0;
    localparam logic [MODE_WIDTH-1:0] MODE_SQUARE = 2'd1;
    localparam logic [MODE_WIDTH-1:0] MODE_SAW    = 2'd2;
    localparam logic [MODE_WIDTH-1:0] MODE_TRI    = 2'd3;

    // Per-channel control word held in both the shadow and active register files.
    typedef struct packed {
        logic [MODE_WIDTH-1:0] mode;
        logic [AMP_WIDTH-1:0]  amp;
        logic                  phase_rst;
    } ch_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } sweep_state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        int unsigned w;
        w = clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

    // Quarter-wave table entry: round(full_scale * sin((idx + 0.5) * pi / 2^(addr_w+1))).
    // Taylor series keeps the evaluation free of math-library calls.
    function automatic int sine_entry(input int unsigned idx, input int unsigned addr_w,
                                      input int unsigned sample_w);
        real x;
        real term;
        real sum;
        real full;
        x    = (real'(idx) + 0.5) * 3.14159265358979323846 / real'(longint'(1) << (addr_w + 1));
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        full = real'((longint'(1) << (sample_w - 1)) - 1);
        return $rtoi(sum * full + 0.5);
    endfunction

endpackage

// File: rtl/wave_shaper.sv
// Pipeline stage 1: maps the top phase bits to a signed raw sample for the selected mode.
module wave_shaper
    import wavegen_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH   = 16,
    parameter int unsigned LUT_ADDR_WIDTH = 8,
    parameter int unsigned TOP_W          = 17,
    parameter int unsigned CH_W           = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_vld,
    input  logic [CH_W-1:0]                in_ch,
    input  logic [MODE_WIDTH-1:0]          in_mode,
    input  logic [TOP_W-1:0]               in_phase,
    output logic                           out_vld,
    output logic [CH_W-1:0]                out_ch,
    output logic signed [SAMPLE_WIDTH-1:0] out_sample
);

    localparam int unsigned MSB       = TOP_W - 1;
    localparam int unsigned LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
    localparam logic [SAMPLE_WIDTH-1:0] POS_FULL = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic [SAMPLE_WIDTH-1:0] NEG_FULL = {1'b1, {(SAMPLE_WIDTH-2){1'b0}}, 1'b1};

    logic [SAMPLE_WIDTH-1:0]   lut [LUT_DEPTH];
    logic [LUT_ADDR_WIDTH-1:0] lut_idx_c;
    logic [SAMPLE_WIDTH-1:0]   lut_mag_c;
    logic [SAMPLE_WIDTH:0]     tri_top_c;
    logic [SAMPLE_WIDTH-1:0]   tri_fold_c;
    logic [SAMPLE_WIDTH-1:0]   raw_c;

    // Quarter-wave sine ROM, constant-folded at elaboration.
    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_lut
        localparam logic [SAMPLE_WIDTH-1:0] ENTRY =
            SAMPLE_WIDTH'(sine_entry(i, LUT_ADDR_WIDTH, SAMPLE_WIDTH));
        assign lut[i] = ENTRY;
    end

    // Mode mux: quadrant folding for sine, sign for square, offset-binary flip for saw/triangle.
    always_comb begin
        raw_c      = '0;
        lut_idx_c  = in_phase[MSB-2 -: LUT_ADDR_WIDTH];
        if (in_phase[MSB-1]) begin
            lut_idx_c = ~lut_idx_c;
        end
        lut_mag_c  = lut[lut_idx_c];
        tri_top_c  = in_phase[MSB -: SAMPLE_WIDTH+1];
        tri_fold_c = tri_top_c[SAMPLE_WIDTH] ? ~tri_top_c[SAMPLE_WIDTH-1:0]
                                             : tri_top_c[SAMPLE_WIDTH-1:0];
        case (in_mode)
            MODE_SINE:   raw_c = in_phase[MSB] ? -lut_mag_c : lut_mag_c;
            MODE_SQUARE: raw_c = in_phase[MSB] ? NEG_FULL : POS_FULL;
            MODE_SAW:    raw_c = {~in_phase[MSB], in_phase[MSB-1 -: SAMPLE_WIDTH-1]};
            MODE_TRI:    raw_c = {~tri_fold_c[SAMPLE_WIDTH-1], tri_fold_c[SAMPLE_WIDTH-2:0]};
        endcase
    end

    // Output register for the stage, carrying valid and channel tag alongside.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_vld    <= 1'b0;
            out_ch     <= '0;
            out_sample <= '0;
        end else begin
            out_vld    <= in_vld;
            out_ch     <= in_ch;
            out_sample <= raw_c;
        end
    end

endmodule

// File: rtl/wavegen_mc.sv
// Multi-channel DDS: per-frame sweep of NUM_CH channels through a 3-stage shared pipeline.
module wavegen_mc
    import wavegen_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned PHASE_WIDTH    = 24,
    parameter int unsigned SAMPLE_WIDTH   = 16,
    parameter int unsigned LUT_ADDR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clk_en,
    input  logic                           cfg_we,
    input  logic [ch_width(NUM_CH)-1:0]    cfg_ch,
    input  logic [PHASE_WIDTH-1:0]         cfg_ftw,
    input  logic [MODE_WIDTH-1:0]          cfg_mode,
    input  logic [AMP_WIDTH-1:0]           cfg_amp,
    input  logic                           cfg_phase_rst,
    output logic [NUM_CH*SAMPLE_WIDTH-1:0] ch_samples,
    output logic [SAMPLE_WIDTH-1:0]        mix_out,
    output logic                           frame_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned CH_W    = ch_width(NUM_CH);
    localparam int unsigned LOG2_CH = clog2(NUM_CH);
    localparam int unsigned ACC_W   = SAMPLE_WIDTH + LOG2_CH;
    localparam int unsigned PROD_W  = SAMPLE_WIDTH + AMP_WIDTH + 1;
    localparam int unsigned TOP_W   = (SAMPLE_WIDTH + 1 > LUT_ADDR_WIDTH + 2) ?
                                      SAMPLE_WIDTH + 1 : LUT_ADDR_WIDTH + 2;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]    CH_LIM  = (CH_W+1)'(NUM_CH);

    logic [PHASE_WIDTH-1:0] sh_ftw    [NUM_CH];
    ch_ctrl_t               sh_ctrl   [NUM_CH];
    logic [PHASE_WIDTH-1:0] act_ftw   [NUM_CH];
    ch_ctrl_t               act_ctrl  [NUM_CH];
    logic [PHASE_WIDTH-1:0] phase_ram [NUM_CH];

    sweep_state_t state;
    sweep_state_t state_nx;
    logic [CH_W-1:0] ch_cnt;
    logic accept_c;
    logic issue_c;
    logic frame_end_c;
    logic cfg_hit_c;

    logic [PHASE_WIDTH-1:0] phase_base_c;
    logic [PHASE_WIDTH-1:0] phase_new_c;
    logic                   s0_vld;
    logic [CH_W-1:0]        s0_ch;
    logic [MODE_WIDTH-1:0]  s0_mode;
    logic [TOP_W-1:0]       s0_top;

    logic                           s1_vld;
    logic [CH_W-1:0]                s1_ch;
    logic signed [SAMPLE_WIDTH-1:0] s1_raw;

    logic signed [PROD_W-1:0]       prod_c;
    logic signed [SAMPLE_WIDTH-1:0] scaled_c;
    logic signed [ACC_W-1:0]        acc;
    logic                           s2_last;

    assign cfg_hit_c = cfg_we && ({1'b0, cfg_ch} < CH_LIM);

    // Shadow register file: host writes, phase_rst flags consumed at frame accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_ftw[i]  <= '0;
                sh_ctrl[i] <= '0;
            end
        end else begin
            if (accept_c) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    sh_ctrl[i].phase_rst <= 1'b0;
                end
            end
            // A write in the accept cycle wins over the clear and lands for the next frame.
            if (cfg_hit_c) begin
                sh_ftw[cfg_ch]  <= cfg_ftw;
                sh_ctrl[cfg_ch] <= '{mode: cfg_mode, amp: cfg_amp, phase_rst: cfg_phase_rst};
            end
        end
    end

    // Active register file: frozen copy of the shadows for the duration of a sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                act_ftw[i]  <= '0;
                act_ctrl[i] <= '0;
            end
        end else if (accept_c) begin
            for (int i = 0; i < NUM_CH; i++) begin
                act_ftw[i]  <= sh_ftw[i];
                act_ctrl[i] <= sh_ctrl[i];
            end
        end
    end

    // Sweep FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Sweep FSM next state: issue one channel per cycle, then wait for the last to clear stage 2.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (clk_en)            state_nx = ST_SWEEP;
            ST_SWEEP: if (ch_cnt == LAST_CH) state_nx = ST_DRAIN;
            ST_DRAIN: if (s2_last)           state_nx = ST_IDLE;
            default:                         state_nx = ST_IDLE;
        endcase
    end

    // Sweep FSM control decodes.
    always_comb begin
        accept_c    = 1'b0;
        issue_c     = 1'b0;
        frame_end_c = 1'b0;
        case (state)
            ST_IDLE:  accept_c    = clk_en;
            ST_SWEEP: issue_c     = 1'b1;
            ST_DRAIN: frame_end_c = s2_last;
            default:  ;
        endcase
    end

    // Channel counter for stage 0 issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ch_cnt <= '0;
        end else if (accept_c) begin
            ch_cnt <= '0;
        end else if (issue_c) begin
            ch_cnt <= ch_cnt + CH_W'(1);
        end
    end

    // Busy mirrors the sweep; overrun latches any strobe arriving mid-sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy <= (state_nx != ST_IDLE);
            if (clk_en && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    // Stage 0 phase update for the channel being issued.
    always_comb begin
        phase_base_c = act_ctrl[ch_cnt].phase_rst ? '0 : phase_ram[ch_cnt];
        phase_new_c  = phase_base_c + act_ftw[ch_cnt];
    end

    // Stage 0: phase RAM write-back and hand-off of the top phase bits to the shaper.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase_ram[i] <= '0;
            end
            s0_vld  <= 1'b0;
            s0_ch   <= '0;
            s0_mode <= '0;
            s0_top  <= '0;
        end else begin
            s0_vld <= issue_c;
            if (issue_c) begin
                phase_ram[ch_cnt] <= phase_new_c;
                s0_ch             <= ch_cnt;
                s0_mode           <= act_ctrl[ch_cnt].mode;
                s0_top            <= phase_new_c[PHASE_WIDTH-1 -: TOP_W];
            end
        end
    end

    wave_shaper #(
        .SAMPLE_WIDTH   (SAMPLE_WIDTH),
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH),
        .TOP_W          (TOP_W),
        .CH_W           (CH_W)
    ) u_shaper (
        .clk        (clk),
        .reset      (reset),
        .in_vld     (s0_vld),
        .in_ch      (s0_ch),
        .in_mode    (s0_mode),
        .in_phase   (s0_top),
        .out_vld    (s1_vld),
        .out_ch     (s1_ch),
        .out_sample (s1_raw)
    );

    // Stage 2 amplitude scaling, floor division by 256.
    always_comb begin
        prod_c   = PROD_W'(s1_raw) * PROD_W'($signed({1'b0, act_ctrl[s1_ch].amp}));
        scaled_c = SAMPLE_WIDTH'(prod_c >>> AMP_WIDTH);
    end

    // Stage 2: per-channel sample registers, mix accumulation and frame completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ch_samples  <= '0;
            mix_out     <= '0;
            frame_valid <= 1'b0;
            acc         <= '0;
            s2_last     <= 1'b0;
        end else begin
            frame_valid <= frame_end_c;
            s2_last     <= s1_vld && (s1_ch == LAST_CH);
            if (s1_vld) begin
                ch_samples[s1_ch*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= scaled_c;
            end
            if (frame_end_c) begin
                mix_out <= SAMPLE_WIDTH'(acc >>> LOG2_CH);
                acc     <= '0;
            end else if (s1_vld) begin
                acc <= acc + ACC_W'(scaled_c);
            end
        end
    end

endmodule

// File: tb/tb_wavegen_mc.sv
// Directed self-checking bench for wavegen_mc (default 4-channel build plus a 5-channel build).
module tb_wavegen_mc;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [23:0] cfg_ftw;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_amp;
    logic        cfg_phase_rst;
    logic [63:0] ch_samples;
    logic [15:0] mix_out;
    logic        frame_valid;
    logic        busy;
    logic        overrun;

    logic        b_clk_en;
    logic        b_cfg_we;
    logic [2:0]  b_cfg_ch;
    logic [23:0] b_cfg_ftw;
    logic [1:0]  b_cfg_mode;
    logic [7:0]  b_cfg_amp;
    logic        b_cfg_phase_rst;
    logic [79:0] b_ch_samples;
    logic [15:0] b_mix_out;
    logic        b_frame_valid;
    logic        b_busy;
    logic        b_overrun;

    int checks = 0;
    int failures = 0;

    wavegen_mc dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_ftw(cfg_ftw), .cfg_mode(cfg_mode), .cfg_amp(cfg_amp), .cfg_phase_rst(cfg_phase_rst),
        .ch_samples(ch_samples), .mix_out(mix_out), .frame_valid(frame_valid),
        .busy(busy), .overrun(overrun)
    );

    wavegen_mc #(.NUM_CH(5)) dut5 (
        .clk(clk), .reset(reset), .clk_en(b_clk_en), .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch),
        .cfg_ftw(b_cfg_ftw), .cfg_mode(b_cfg_mode), .cfg_amp(b_cfg_amp),
        .cfg_phase_rst(b_cfg_phase_rst), .ch_samples(b_ch_samples), .mix_out(b_mix_out),
        .frame_valid(b_frame_valid), .busy(b_busy), .overrun(b_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint chs(input int k);
        logic signed [15:0] v;
        v = ch_samples[16*k +: 16];
        return longint'(v);
    endfunction

    function automatic longint mix;
        logic signed [15:0] v;
        v = mix_out;
        return longint'(v);
    endfunction

    task automatic cfg(input logic [1:0] ch, input logic [23:0] ftw, input logic [1:0] mode,
                       input logic [7:0] amp, input logic prst);
        cfg_ch = ch; cfg_ftw = ftw; cfg_mode = mode; cfg_amp = amp; cfg_phase_rst = prst;
        cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic start_frame;
        clk_en = 1'b1;
        tick;
        clk_en = 1'b0;
    endtask

    // Cycles from the accepting edge until frame_valid is seen; capped at 40.
    task automatic wait_fv(input int start, output int lat);
        lat = start;
        while (lat < 40) begin
            tick;
            lat++;
            if (frame_valid) break;
        end
    endtask

    task automatic run_frame(input string tag);
        int lat;
        start_frame;
        wait_fv(1, lat);
        lat = lat - 1;
        check({tag, "_lat"}, lat, 7);
    endtask

    initial begin
        int lat;
        int n;
        int bad;
        int flips;
        int first_flip;
        longint s [0:64];
        longint mx;
        longint mn;
        logic signed [15:0] bv;

        reset = 1'b0; clk_en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_ftw = '0;
        cfg_mode = '0; cfg_amp = '0; cfg_phase_rst = 1'b0;
        b_clk_en = 1'b0; b_cfg_we = 1'b0; b_cfg_ch = '0; b_cfg_ftw = '0;
        b_cfg_mode = '0; b_cfg_amp = '0; b_cfg_phase_rst = 1'b0;
        repeat (3) tick;
        check("rst_ch", longint'(ch_samples), 0);
        check("rst_mix", mix(), 0);
        check("rst_fv", longint'(frame_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_ovr", longint'(overrun), 0);
        reset = 1'b1;
        tick;

        // Square on ch0, quarter-turn per frame.
        cfg(2'd0, 24'h400000, 2'd1, 8'd255, 1'b0);
        start_frame;
        check("t1_busy", longint'(busy), 1);
        wait_fv(1, lat);
        check("t1f1_lat", lat - 1, 7);
        check("t1f1_ch0", chs(0), 32639);
        check("t1f1_mix", mix(), 8159);
        tick;
        check("t1_fv_pulse", longint'(frame_valid), 0);
        check("t1_busy_clr", longint'(busy), 0);
        run_frame("t1f2");
        check("t1f2_ch0", chs(0), -32640);
        check("t1f2_mix", mix(), -8160);
        run_frame("t1f3");
        check("t1f3_ch0", chs(0), -32640);
        check("t1f3_mix", mix(), -8160);
        run_frame("t1f4");
        check("t1f4_ch0", chs(0), 32639);
        check("t1f4_mix", mix(), 8159);
        check("t1f4_ch1", chs(1), 0);

        // Saw at phase 0 on ch1, then amplitude 0.
        cfg(2'd1, 24'h000000, 2'd2, 8'd255, 1'b1);
        run_frame("t2a");
        check("t2a_ch1", chs(1), -32640);
        check("t2a_ch0", chs(0), 32639);
        check("t2a_mix", mix(), -1);
        cfg(2'd1, 24'h000000, 2'd2, 8'd0, 1'b0);
        run_frame("t2b");
        check("t2b_ch1", chs(1), 0);
        check("t2b_mix", mix(), -8160);

        // Shadow timing and phase reset on ch0 (saw).
        cfg(2'd0, 24'h100000, 2'd2, 8'd255, 1'b1);
        run_frame("t3a");
        check("t3a_ch0", chs(0), -28560);
        check("t3a_mix", mix(), -7140);
        start_frame;
        tick;
        cfg_ch = 2'd0; cfg_ftw = 24'h200000; cfg_mode = 2'd2; cfg_amp = 8'd255;
        cfg_phase_rst = 1'b0; cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
        wait_fv(2, lat);
        check("t3b_lat", lat, 7);
        check("t3b_ch0_old", chs(0), -24480);
        run_frame("t3c");
        check("t3c_ch0_new", chs(0), -16320);
        cfg(2'd0, 24'h200000, 2'd2, 8'd255, 1'b1);
        run_frame("t3d");
        check("t3d_ch0_prst", chs(0), -24480);
        run_frame("t3e");
        check("t3e_ch0_noprst", chs(0), -16320);

        // Strobe while busy: one frame only, sticky overrun.
        check("t4_ovr_pre", longint'(overrun), 0);
        start_frame;
        tick;
        clk_en = 1'b1;
        tick;
        clk_en = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame_valid) n++;
            tick;
        end
        check("t4_fv_count", n, 1);
        check("t4_ovr", longint'(overrun), 1);
        run_frame("t4b");
        check("t4_ovr_held", longint'(overrun), 1);

        // Out-of-range channel ignored on the 5-channel build.
        b_cfg_ch = 3'd4; b_cfg_ftw = '0; b_cfg_mode = 2'd1; b_cfg_amp = 8'd255;
        b_cfg_phase_rst = 1'b0; b_cfg_we = 1'b1;
        tick;
        b_cfg_ch = 3'd5;
        tick;
        b_cfg_we = 1'b0;
        b_clk_en = 1'b1;
        tick;
        b_clk_en = 1'b0;
        lat = 0;
        while (lat < 40) begin
            tick;
            lat++;
            if (b_frame_valid) break;
        end
        check("t4_b_lat", lat, 8);
        bv = b_ch_samples[64 +: 16];
        check("t4_b_ch4", longint'(bv), 32639);
        check("t4_b_ch0_3", longint'(b_ch_samples[63:0]), 0);
        bv = b_mix_out;
        check("t4_b_mix", longint'(bv), 4079);

        // Reset mid-sweep aborts the frame.
        start_frame;
        tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        check("t5_busy", longint'(busy), 0);
        check("t5_ch", longint'(ch_samples), 0);
        check("t5_mix", mix(), 0);
        check("t5_ovr", longint'(overrun), 0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (frame_valid) n++;
            tick;
        end
        check("t5_fv_count", n, 0);
        cfg(2'd0, 24'h000000, 2'd1, 8'd255, 1'b0);
        run_frame("t5b");
        check("t5b_ch0", chs(0), 32639);
        check("t5b_mix", mix(), 8159);

        // Sine sweep: 64 frames per period on ch0.
        cfg(2'd0, 24'h040000, 2'd0, 8'd255, 1'b1);
        bad = 0;
        s[0] = 0;
        for (int f = 1; f <= 64; f++) begin
            start_frame;
            wait_fv(1, lat);
            if (lat != 8) bad++;
            s[f] = chs(0);
        end
        check("t6_lat_bad", bad, 0);
        check("t6_f16", s[16], 32639);
        check("t6_f32", s[32], -101);
        check("t6_f48", s[48], -32640);
        check("t6_f64", s[64], 100);
        check("t6_mix", mix(), 25);
        mx = s[1];
        mn = s[1];
        flips = 0;
        first_flip = 0;
        bad = 0;
        for (int f = 1; f <= 64; f++) begin
            if (s[f] > mx) mx = s[f];
            if (s[f] < mn) mn = s[f];
            if (f > 1 && ((s[f] < 0) != (s[f-1] < 0))) begin
                flips++;
                if (first_flip == 0) first_flip = f;
            end
            if (f <= 32 && !((s[f] + s[f+32] == 0) || (s[f] + s[f+32] == -1))) bad++;
        end
        check("t6_max", mx, 32639);
        check("t6_min", mn, -32640);
        check("t6_flips", flips, 2);
        check("t6_first_flip", first_flip, 32);
        check("t6_symmetry", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
